// File: rtl/tff_ctrl_pkg.sv
// Shared types and constants for the TFF counter controller.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Prescaler counter width; PRESCALE ranges 1..256, so the reload value fits in 8 bits.
  localparam int PRESCALE_W = 8;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles, frozen while en is low.
module tick_gen
  import tff_ctrl_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] RELOAD = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] count_reg;
  logic [PRESCALE_W-1:0] count_next;

  assign tick = en && (count_reg == '0);

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = RELOAD;
    end else if (en) begin
      count_next = (count_reg == '0) ? RELOAD : count_reg - PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= RELOAD;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Drives the toggle inputs of an external TFF bank as a modulo up/down counter.
// Optional macro TFF_CTRL_SATURATE_EN: stop at the wrap point instead of wrapping.
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             up,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             busy,
  output logic             tc
);

  state_t state_reg;
  state_t state_next;
  logic   tick;
  logic   run_en;
  logic   clr;
  logic   step;
  logic   tc_reg;

  logic [WIDTH-1:0] mod_m1;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] t_comb;
  logic             up_wrap;
  logic             down_wrap;
  logic             wrap;

  // The prescaler sits at its reload value throughout IDLE, so entering RUN restarts the phase.
  assign run_en = (state_reg == RUN);
  assign clr    = (state_reg == IDLE);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (run_en),
    .clr  (clr),
    .tick (tick)
  );

  assign step = run_en && tick;

  // modulus == 0 wraps naturally to all-ones here, giving the full 2^WIDTH range.
  assign mod_m1    = modulus - WIDTH'(1);
  assign up_wrap   = (q == mod_m1) || ((modulus != '0) && (q >= modulus));
  assign down_wrap = (q == '0);
  assign wrap      = up ? up_wrap : down_wrap;

  assign t_up[0] = 1'b1;
  assign t_dn[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_toggle
      assign t_up[gi] = &q[gi-1:0];
      assign t_dn[gi] = &(~q[gi-1:0]);
    end
  endgenerate

  always_comb begin
    t_comb = '0;
    if (step) begin
      if (wrap) begin
`ifdef TFF_CTRL_SATURATE_EN
        t_comb = '0;
`else
        t_comb = up ? q : (q ^ mod_m1);
`endif
      end else begin
        t_comb = up ? t_up : t_dn;
      end
    end
  end

  assign t = t_comb;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (!stop && start) state_next = RUN;
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
`ifdef TFF_CTRL_SATURATE_EN
        end else if (step && wrap) begin
          state_next = IDLE;
`endif
        end else if (hold) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!hold) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      tc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      tc_reg    <= step && wrap;
    end
  end

  assign busy = (state_reg != IDLE);
  assign tc   = tc_reg;

endmodule

// File: doc/tff_count_ctrl.md
TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit count of the TFF bank driven.
REQ-002 SHALL have parameter PRESCALE, default 1: clock cycles per count step, range 1..256.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: level; begins counting from IDLE.
REQ-006 SHALL have port stop, input, 1 bit: level; returns the block to IDLE.
REQ-007 SHALL have port hold, input, 1 bit: level; freezes stepping while in RUN.
REQ-008 SHALL have port up, input, 1 bit: direction; 1 means up, 0 means down.
REQ-009 SHALL have port modulus, input, WIDTH bits: count modulus; 0 means 2^WIDTH.
REQ-010 SHALL have port q, input, WIDTH bits: current state read back from the downstream TFF bank.
REQ-011 SHALL have port t, output, WIDTH bits: toggle inputs for the TFF bank.
REQ-012 SHALL have port busy, output, 1 bit: high while the FSM is not IDLE.
REQ-013 SHALL have port tc, output, 1 bit: one-cycle terminal-count pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and HOLD.
- IDLE->RUN on start.
- RUN->HOLD on hold; HOLD->RUN on !hold.
- RUN or HOLD -> IDLE on stop.
REQ-015 SHALL give stop priority over start and hold when they are asserted in the same cycle.
REQ-016 SHALL generate a step tick every PRESCALE cycles while in RUN.
- Prescaler reloads to PRESCALE-1 on entry to RUN.
- Prescaler freezes in HOLD.
- With PRESCALE=1 the tick is high every RUN cycle.
REQ-017 SHALL drive t=0 in every cycle without a tick, and in IDLE and HOLD.
REQ-018 SHALL drive t combinationally from q, up, modulus and the tick in a tick cycle:
- Up, no wrap: t[0]=1, t[i]=&q[i-1:0].
- Down, no wrap: t[0]=1, t[i]=&~q[i-1:0].
REQ-019 SHALL drive t=q on an up wrap, where q==modulus-1 (q==all-ones when modulus=0), so the bank goes to 0.
REQ-020 SHALL drive t=q^(modulus-1) on a down wrap, where q==0, so the bank goes to modulus-1 (all-ones when modulus=0).
REQ-021 SHALL make the TFF bank's new value visible on q one clock after the tick cycle, because t is applied at the next edge.
REQ-022 SHALL assert tc, registered, in the cycle after each wrap tick, for exactly one cycle.
REQ-023 SHALL treat q>=modulus (nonzero modulus) as a wrap condition in the up direction.
REQ-024 SHALL sample modulus and up every cycle; a change takes effect at the next tick.

Reset
REQ-025 SHALL, while reset is low, immediately force: state IDLE, prescaler PRESCALE-1, t=0, busy=0, tc=0.
REQ-026 SHALL, on reset assertion mid-RUN, abort the pending step with no t pulse; the TFF bank is reset by the same net.

Configuration
REQ-027 SHALL support macro TFF_CTRL_SATURATE_EN:
- Defined: a wrap tick is suppressed (t=0), tc still pulses, and the FSM goes to IDLE.
- Undefined: counting wraps as in REQ-019/REQ-020 and the FSM stays in RUN.

Structure
REQ-028 SHALL take the state enum (IDLE/RUN/HOLD) and the PRESCALE width constant from a shared package, tff_ctrl_pkg.
REQ-029 SHALL place the prescaler in sub-module tick_gen, with ports clk, reset, en, clr and tick.

Verification
REQ-030 SHALL cover: WIDTH=4, PRESCALE=1, modulus=10, up=1, start -> with a TFF bank closed around t, q steps 0..9,0; tc pulses once per 10 steps.
REQ-031 SHALL cover: up=0, modulus=10, q=0 at a tick -> t=4'b1001, next q=9, tc pulses.
REQ-032 SHALL cover: PRESCALE=3, RUN, hold raised for 5 cycles -> one step every 3 RUN cycles, no steps during HOLD, phase resumes.
REQ-033 SHALL cover: start and stop both high in IDLE -> FSM stays IDLE, busy=0, t=0.
REQ-034 SHALL cover: reset low mid-RUN at q=5 -> t=0, busy=0 immediately; after release the FSM is in IDLE.
REQ-035 SHALL cover: TFF_CTRL_SATURATE_EN defined, modulus=4, up -> q stops at 3, tc pulses once, busy falls.
